// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - 8N1 serial receiver with mid-bit sampling, framing-error strobe and link-presence flag
module uart_receive #(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_BITS    = 10,
  parameter int BREAK_BITS   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] word,
  output logic       word_valid,
  output logic       frame_error,
  output logic       connection_status
);

  localparam int HALF       = CLKS_PER_BIT / 2;
  localparam int IDLE_TERM  = IDLE_BITS * CLKS_PER_BIT;
  localparam int BREAK_TERM = BREAK_BITS * CLKS_PER_BIT;
  localparam int RUN_MAX    = (IDLE_TERM > BREAK_TERM) ? IDLE_TERM : BREAK_TERM;
  localparam int RUN_W      = $clog2(RUN_MAX + 1);
  localparam int BIT_W      = $clog2(CLKS_PER_BIT);

  localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] FULL_LAST = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [RUN_W-1:0] HIGH_TERM = RUN_W'(IDLE_TERM);
  localparam logic [RUN_W-1:0] LOW_TERM  = RUN_W'(BREAK_TERM);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic             sync1;
  logic             rxd_s;
  logic [2:0]       state;
  logic [BIT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic [RUN_W-1:0] high_run;
  logic [RUN_W-1:0] low_run;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  // Frame recovery: start detect, mid-bit sampling of data and stop bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A line back high at mid start bit was only a glitch
            if (!rxd_s) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxd_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              word       <= shreg;
              word_valid <= 1'b1;
              state      <= S_IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // Hold off until the line recovers so a stuck-low line reports once
          if (rxd_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Link presence: saturating high/low run lengths on the synchronised line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_run          <= '0;
      low_run           <= '0;
      connection_status <= 1'b0;
    end else begin
      if (rxd_s) begin
        low_run <= '0;
        if (high_run != HIGH_TERM) begin
          high_run <= high_run + 1'b1;
        end
      end else begin
        high_run <= '0;
        if (low_run != LOW_TERM) begin
          low_run <= low_run + 1'b1;
        end
      end
      if (high_run == HIGH_TERM) begin
        connection_status <= 1'b1;
      end else if (low_run == LOW_TERM) begin
        connection_status <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb/tb_uart_receive.sv - directed self-checking bench for uart_receive
module tb_uart_receive;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxd4;
  logic [7:0] word, word4;
  logic       word_valid, word_valid4;
  logic       frame_error, frame_error4;
  logic       connection_status, connection_status4;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int start_edge = 0;

  int vld_count = 0, last_vld_cyc = 0, prev_vld_cyc = 0, fe_count = 0;
  int vld4_count = 0, last_vld4_cyc = 0, fe4_count = 0;
  int overlap = 0, long_pulse = 0;
  logic pv = 1'b0, pf = 1'b0;

  uart_receive dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .word(word), .word_valid(word_valid), .frame_error(frame_error),
    .connection_status(connection_status)
  );

  uart_receive #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4),
    .word(word4), .word_valid(word_valid4), .frame_error(frame_error4),
    .connection_status(connection_status4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (word_valid) begin
      vld_count++;
      prev_vld_cyc = last_vld_cyc;
      last_vld_cyc = cyc;
    end
    if (frame_error) fe_count++;
    if (word_valid && frame_error) overlap++;
    if ((word_valid && pv) || (frame_error && pf)) long_pulse++;
    pv = word_valid;
    pf = frame_error;
    if (word_valid4) begin
      vld4_count++;
      last_vld4_cyc = cyc;
    end
    if (frame_error4) fe4_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input bit on4);
    if (on4) rxd4 = v;
    else     rxd  = v;
  endtask

  // Drives nbits of a frame starting at a negedge; line is left at the last bit
  task automatic send_bits(input logic [7:0] b, input logic stop_bit, input int cpb,
                           input bit on4, input int nbits);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      drive(f[i], on4);
      if (i == 0) start_edge = cyc + 1;
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int cpb, input bit on4);
    send_bits(b, stop_bit, cpb, on4, 10);
  endtask

  initial begin
    int s1;
    rst  = 1'b0;
    rxd  = 1'b1;
    rxd4 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_word", word, 8'h00);
    check("rst_valid", word_valid, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_status", connection_status, 1'b0);
    rst = 1'b1;

    // Idle line: link comes up after 160 high cycles
    repeat (100) @(negedge clk);
    check("status_early", connection_status, 1'b0);
    repeat (100) @(negedge clk);
    check("status_up", connection_status, 1'b1);

    send_frame(8'h81, 1'b1, 16, 1'b0);
    repeat (4) @(negedge clk);
    check("f81_word", word, 8'h81);
    check("f81_count", vld_count, 1);
    check("f81_latency", last_vld_cyc - start_edge, 154);
    check("f81_ferr", fe_count, 0);

    // Short low glitch aborts in START
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", vld_count, 1);
    check("glitch_ferr", fe_count, 0);
    check("glitch_word", word, 8'h81);

    // Back-to-back frames
    send_frame(8'h81, 1'b1, 16, 1'b0);
    s1 = start_edge;
    check("b2b_first_word", word, 8'h81);
    check("b2b_first_lat", last_vld_cyc - s1, 154);
    send_frame(8'h00, 1'b1, 16, 1'b0);
    repeat (4) @(negedge clk);
    check("b2b_second_word", word, 8'h00);
    check("b2b_count", vld_count, 3);
    check("b2b_spacing", last_vld_cyc - prev_vld_cyc, 160);

    send_frame(8'h5A, 1'b1, 16, 1'b0);
    repeat (4) @(negedge clk);
    check("f5a_word", word, 8'h5A);

    // Bad stop bit, line held low
    send_frame(8'hA5, 1'b0, 16, 1'b0);
    repeat (200) @(negedge clk);
    check("ferr_status_hold", connection_status, 1'b1);
    repeat (200) @(negedge clk);
    check("ferr_count", fe_count, 1);
    check("ferr_word", word, 8'h5A);
    check("ferr_vcount", vld_count, 4);
    check("break_status", connection_status, 1'b0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'hC3, 1'b1, 16, 1'b0);
    repeat (4) @(negedge clk);
    check("recover_word", word, 8'hC3);
    check("recover_count", vld_count, 5);

    // Reset in the middle of data bit 4
    send_bits(8'h3C, 1'b1, 16, 1'b0, 5);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_word", word, 8'h00);
    check("midrst_status", connection_status, 1'b0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (120) @(negedge clk);
    check("midrst_count", vld_count, 5);
    send_frame(8'h3C, 1'b1, 16, 1'b0);
    repeat (4) @(negedge clk);
    check("after_rst_word", word, 8'h3C);
    check("after_rst_count", vld_count, 6);

    // Minimum bit period instance
    send_frame(8'hFF, 1'b1, 4, 1'b1);
    repeat (4) @(negedge clk);
    check("cpb4_word", word4, 8'hFF);
    check("cpb4_count", vld4_count, 1);
    check("cpb4_latency", last_vld4_cyc - start_edge, 40);
    check("cpb4_ferr", fe4_count, 0);

    check("strobe_overlap", overlap, 0);
    check("strobe_width", long_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- Serial 8N1 receiver; the downstream partner of the transmit stage. Consumes the txd line on its rxd input.
- Recovers each byte by mid-bit sampling against a fixed clocks-per-bit count.
- Presents each byte on word with a one-cycle valid strobe.
- Flags framing errors and reports link presence on connection_status.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, minimum 4; must match the transmitter.
- IDLE_BITS, 10, consecutive high bit-times on rxd before connection_status asserts.
- BREAK_BITS, 20, consecutive low bit-times on rxd before connection_status deasserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idles high; asynchronous to clk.
- word  output  8  last correctly received byte.
- word_valid  output  1  one-cycle strobe when word updates.
- frame_error  output  1  one-cycle strobe when a stop bit samples low.
- connection_status  output  1  high while the link is judged present.

Behaviour:
- Reset (rst=0, async): word=0, word_valid=0, frame_error=0, connection_status=0, state=IDLE, all counters 0, synchroniser flops=1. Release is synchronous to clk.
- rxd passes through a 2-flop synchroniser; its output is rxd_s. All logic uses rxd_s only.
- Frame format: start bit 0, 8 data bits LSB first, 1 stop bit 1.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when rxd_s=0, go to START and clear the bit counter.
- START: count CLKS_PER_BIT/2 cycles, then sample.
  - rxd_s=0: go to DATA, bit index=0, counter=0.
  - rxd_s=1: glitch; return to IDLE with no strobe.
- DATA: sample every CLKS_PER_BIT cycles and shift into bit[index].
  - After the sample for index 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample.
  - rxd_s=1: word<=shift register, word_valid=1 for one cycle, go to IDLE. A start bit is accepted on the very next cycle, so back-to-back frames work.
  - rxd_s=0: frame_error=1 for one cycle, word unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s=1, then go to IDLE. A held-low line produces only one frame_error.
- Latency: let edge 0 be the rising edge at which the first sync flop captures rxd=0. word_valid is high in the cycle after edge 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (edge 154 at default).
- word_valid and frame_error are never high together. Neither is ever high for more than one cycle.
- connection_status:
  - Independent high-run and low-run counters on rxd_s, each saturating; opposite level clears each counter.
  - Set to 1 when the high-run reaches IDLE_BITS*CLKS_PER_BIT.
  - Cleared to 0 when the low-run reaches BREAK_BITS*CLKS_PER_BIT.
  - Otherwise holds. Data reception does not depend on it.
- Reset mid-frame: all state is lost and no strobe is issued. After release the receiver waits in IDLE; a line already low starts a frame immediately (treated as a start bit).
- Counter widths: sized by clog2 of the largest terminal count. No wrap below saturation.

Test Plan:
- rxd high 200 cycles, then frame 0x81 at 16 clk/bit -> connection_status=1 after 160 high cycles. word=0x81 with word_valid high exactly one cycle at edge 154 from start detection. frame_error stays 0.
- Back-to-back frames 0x81 then 0x00, no idle gap -> two word_valid pulses 160 cycles apart. word=0x81 then 0x00.
- 4-cycle low glitch on an idle line -> START aborts at mid-bit. No word_valid, no frame_error, word unchanged.
- Frame 0xA5 with stop bit forced 0, line then held low 400 cycles -> single frame_error pulse, word keeps its prior value. connection_status drops to 0 after 320 consecutive low cycles. The next valid frame after the line returns high is received correctly.
- rst pulsed low during DATA bit 4 of frame 0x3C -> outputs are 0 immediately (async). No strobe for the aborted frame. A subsequent 0x3C is received cleanly.
- CLKS_PER_BIT=4 instance, frame 0xFF -> word=0xFF, word_valid at edge 2+2+36=40.
